// File: rtl/regfile_dump_pkg.sv
// Shared state encoding and default sizing for the register-file dump engine.
package regfile_dump_pkg;

  localparam int REG_SIZE  = 32;
  localparam int ADDR_BITS = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dump_state_t;

endpackage

// File: rtl/reg_file_3bus.sv
// Three-bus register file: two combinational read ports and one synchronous write port.
// Register x0 always reads as zero and ignores writes.
module reg_file_3bus #(
  parameter int Reg_size  = 32,
  parameter int Addr_bits = 5
) (
  input  logic                       clk,
  input  logic                       WE3,
  input  logic [Addr_bits-1:0]       A1,
  input  logic [Addr_bits-1:0]       A2,
  input  logic [Addr_bits-1:0]       A3,
  input  logic signed [Reg_size-1:0] WD3,
  output logic signed [Reg_size-1:0] RD1,
  output logic signed [Reg_size-1:0] RD2
);

  logic signed [Reg_size-1:0] regs [2**Addr_bits];

  always_ff @(posedge clk) begin
    if (WE3 && (A3 != '0)) begin
      regs[A3] <= WD3;
    end
  end

  assign RD1 = (A1 == '0) ? '0 : regs[A1];
  assign RD2 = (A2 == '0) ? '0 : regs[A2];

endmodule

// File: rtl/regfile_dump.sv
// Walks every register of an external file and streams (addr, data) beats on a valid/ready port.
// Stalled beats hold stable; REGDUMP_CHECKSUM_EN adds an XOR checksum of all accepted beats.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int Reg_size  = REG_SIZE,
  parameter int Addr_bits = ADDR_BITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic [Addr_bits-1:0]       A1,
  input  logic signed [Reg_size-1:0] RD1,
  output logic                       dump_valid,
  input  logic                       dump_ready,
  output logic [Addr_bits-1:0]       dump_addr,
  output logic signed [Reg_size-1:0] dump_data,
  output logic                       busy,
  output logic                       done
`ifdef REGDUMP_CHECKSUM_EN
  ,
  output logic [Reg_size-1:0]        checksum
`endif
);

  localparam logic [Addr_bits-1:0] LAST_ADDR = {Addr_bits{1'b1}};

  dump_state_t          state;
  dump_state_t          state_nxt;
  logic [Addr_bits-1:0] cnt;
  logic                 load;
  logic                 hs;

  // A new beat may be loaded when the output slot is empty or being drained this cycle.
  assign load = (state == READ) && (!dump_valid || dump_ready);
  assign hs   = dump_valid && dump_ready;
  assign A1   = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    if (load && (cnt == LAST_ADDR)) state_nxt = DRAIN;
      DRAIN:   if (hs) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      READ, DRAIN: busy = 1'b1;
      DONE:        done = 1'b1;
      default:     ;
    endcase
  end

  // The counter wraps to 0 on loading the last address, so it is already clear in DRAIN/DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
    end else begin
      if (state == IDLE) begin
        cnt <= '0;
      end else if (load) begin
        cnt <= cnt + 1'b1;
      end

      if (load) begin
        dump_valid <= 1'b1;
        dump_addr  <= cnt;
        dump_data  <= RD1;
      end else if (hs) begin
        dump_valid <= 1'b0;
      end
    end
  end

`ifdef REGDUMP_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum <= '0;
    end else if ((state == IDLE) && start) begin
      checksum <= '0;
    end else if (hs) begin
      checksum <= checksum ^ dump_data;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump driving a preloaded reg_file_3bus; define REGDUMP_CHECKSUM_EN for the checksum checks.
module tb_regfile_dump;
  import regfile_dump_pkg::*;

  localparam int RS = REG_SIZE;
  localparam int AB = ADDR_BITS;
  localparam int N  = 2**AB;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic                 dump_ready = 1'b0;
  logic                 we3 = 1'b0;
  logic [AB-1:0]        a1;
  logic [AB-1:0]        a2 = '0;
  logic [AB-1:0]        a3 = '0;
  logic signed [RS-1:0] wd3 = '0;
  logic signed [RS-1:0] rd1;
  logic signed [RS-1:0] rd2;
  logic                 dump_valid;
  logic [AB-1:0]        dump_addr;
  logic signed [RS-1:0] dump_data;
  logic                 busy;
  logic                 done;
`ifdef REGDUMP_CHECKSUM_EN
  logic [RS-1:0]        checksum;
`endif

  int passed = 0;
  int total  = 0;
  int beats;
  int dones;
  logic [RS-1:0] cs_model;

  always #5 clk = ~clk;

  reg_file_3bus #(.Reg_size(RS), .Addr_bits(AB)) u_rf (
    .clk(clk), .WE3(we3), .A1(a1), .A2(a2), .A3(a3), .WD3(wd3), .RD1(rd1), .RD2(rd2)
  );

  regfile_dump #(.Reg_size(RS), .Addr_bits(AB)) dut (
    .clk(clk), .rst(rst), .start(start), .A1(a1), .RD1(rd1),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
    .dump_data(dump_data), .busy(busy), .done(done)
`ifdef REGDUMP_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int exp_val(input int a);
    return (a == 0) ? 0 : 100 + 4 * a;
  endfunction

  // mode 0: ready always high; mode 1: ready toggles 1,0,1,0 per cycle.
  task automatic run_dump(input int mode, input int restart_at, input int rst_at,
                          output int nbeats, output int ndones);
    int exp_addr = 0;
    int last_hs = -10;
    int done_cyc = 0;
    logic prev_hold = 1'b0;
    logic restarted = 1'b0;
    logic [AB-1:0] prev_addr = '0;
    logic signed [RS-1:0] prev_data = '0;
    nbeats = 0;
    ndones = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_in_read", busy, 1);
    chk("a1_start_zero", a1, 0);
    chk("no_beat_on_entry", dump_valid, 0);
`ifdef REGDUMP_CHECKSUM_EN
    chk("checksum_cleared", checksum, 0);
`endif
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (rst_at >= 0 && nbeats == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", dump_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_a1", a1, 0);
        chk("rst_addr", dump_addr, 0);
        chk("rst_data", dump_data, 0);
`ifdef REGDUMP_CHECKSUM_EN
        chk("rst_checksum", checksum, 0);
`endif
        break;
      end
      dump_ready = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
      if (restart_at >= 0 && nbeats == restart_at && !restarted) begin
        start = 1'b1;
        restarted = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (cyc == 0) chk("first_beat_latency", dump_valid, 1);
      if (dump_valid) begin
        if (prev_hold) begin
          chk("hold_addr", dump_addr, prev_addr);
          chk("hold_data", dump_data, prev_data);
        end
        if (dump_ready) begin
          chk("beat_addr", dump_addr, exp_addr);
          chk("beat_data", dump_data, exp_val(exp_addr));
          if (mode == 0 && nbeats > 0) chk("throughput", cyc, last_hs + 1);
          last_hs = cyc;
          exp_addr++;
          nbeats++;
        end
        prev_hold = !dump_ready;
        prev_addr = dump_addr;
        prev_data = dump_data;
      end else begin
        prev_hold = 1'b0;
      end
      if (done) begin
        ndones++;
        done_cyc = cyc;
        chk("done_after_last", cyc, last_hs + 1);
        chk("beats_at_done", nbeats, N);
        chk("valid_at_done", dump_valid, 0);
`ifdef REGDUMP_CHECKSUM_EN
        chk("checksum_value", checksum, cs_model);
`endif
      end
      if (ndones > 0 && cyc >= done_cyc + 4) break;
    end
    start = 1'b0;
    if (rst_at < 0) begin
      chk("total_beats", nbeats, N);
      chk("done_pulses", ndones, 1);
      chk("idle_after", busy, 0);
`ifdef REGDUMP_CHECKSUM_EN
      chk("checksum_held", checksum, cs_model);
`endif
    end
  endtask

  initial begin
    cs_model = '0;
    for (int i = 1; i < N; i++) cs_model ^= RS'(100 + 4 * i);

    // Reset and preload xi = 100+4*i through the write port.
    for (int i = 1; i < N; i++) begin
      @(negedge clk);
      we3 = 1'b1;
      a3  = AB'(i);
      wd3 = RS'(100 + 4 * i);
    end
    @(negedge clk);
    we3 = 1'b0;
    a2  = AB'(5);
    chk("rf_x5", rd2, 120);
    chk("reset_valid", dump_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_addr", dump_addr, 0);
    chk("reset_data", dump_data, 0);
    chk("reset_a1", a1, 0);
    rst = 1'b0;

    run_dump(0, -1, -1, beats, dones);   // full-rate dump
    run_dump(1, -1, -1, beats, dones);   // alternating backpressure
    run_dump(0, 10, -1, beats, dones);   // start during dump is ignored
    run_dump(0, -1, 15, beats, dones);   // reset mid-dump
    chk("rst_beats_before", beats, 15);
    run_dump(0, -1, -1, beats, dones);   // clean restart from address 0

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
